// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } key_state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Indexed by {row index, column index}; row 0 / column 0 sit at the LSB end.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/hex_keypad_entry_sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the asynchronous keypad column lines.
// Resets to all-ones, the idle (no key) level of the pulled-up columns.
module sync_2ff (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hex_keypad_entry.sv
`timescale 1ns/1ps
// Hex keypad scanner: row rotation, press/release debounce, 4-digit shift entry.
// Optional macro KEYPAD_CLEAR_EN adds a synchronous clr input that zeroes the number.
//
// state    | meaning
// SCAN     | rotate rows one step per sample point, look for a single low column
// DEBOUNCE | row held, counting consecutive samples equal to the latched key
// HELD     | key accepted, waiting for consecutive all-high samples (release)
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef KEYPAD_CLEAR_EN
    input  logic        clr,
`endif
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] hex_num_4digit,
    output logic        WE
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_SCANS);

    key_state_t    state;
    logic [3:0]    col_s;
    logic [SW-1:0] slot_cnt;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_inc;
    logic [3:0]    key_code;
    logic [3:0]    key_col;
    logic [3:0]    row_next;
    logic [3:0]    digit;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic          sample;
    logic          one_low;
    logic          accept;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    always_comb begin
        one_low = 1'b1;
        col_idx = 2'd0;
        case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: one_low = 1'b0;
        endcase

        case (row)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase

        sample    = (slot_cnt == SLOT_LAST);
        key_col   = ~(4'b0001 << key_code[1:0]);
        match_inc = match_cnt + MW'(1);
        row_next  = {row[2:0], row[3]};

        // A single-sample debounce accepts straight out of SCAN.
        accept = 1'b0;
        digit  = KEY_MAP[key_code];
        case (state)
            SCAN: begin
                if (sample && one_low && (DEBOUNCE_SCANS == 1)) begin
                    accept = 1'b1;
                    digit  = KEY_MAP[{row_idx, col_idx}];
                end
            end
            DEBOUNCE: accept = sample && (col_s == key_col) && (match_inc == MATCH_DONE);
            default:  accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= SCAN;
            row            <= ROW_RESET;
            hex_num_4digit <= 16'h0000;
            WE             <= 1'b0;
            slot_cnt       <= '0;
            match_cnt      <= '0;
            key_code       <= 4'h0;
        end else begin
            slot_cnt <= sample ? '0 : slot_cnt + SW'(1);

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (one_low) begin
                            key_code <= {row_idx, col_idx};
                            if (accept) begin
                                state     <= HELD;
                                match_cnt <= '0;
                            end else begin
                                state     <= DEBOUNCE;
                                match_cnt <= MW'(1);
                            end
                        end else begin
                            row <= row_next;
                        end
                    end
                    DEBOUNCE: begin
                        if (col_s == key_col) begin
                            if (accept) begin
                                state     <= HELD;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            state     <= SCAN;
                            match_cnt <= '0;
                            row       <= row_next;
                        end
                    end
                    HELD: begin
                        if (col_s == 4'hF) begin
                            if (match_inc == MATCH_DONE) begin
                                state     <= SCAN;
                                match_cnt <= '0;
                                row       <= row_next;
                            end else begin
                                match_cnt <= match_inc;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= SCAN;
                        match_cnt <= '0;
                    end
                endcase
            end

            WE <= accept;
            if (accept) begin
                hex_num_4digit <= {hex_num_4digit[11:0], digit};
            end
`ifdef KEYPAD_CLEAR_EN
            // Clear overrides a same-cycle accept; the FSM still moves to HELD.
            if (clr) begin
                hex_num_4digit <= 16'h0000;
                WE             <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
`timescale 1ns/1ps
// Self-checking bench for hex_keypad_entry with a per-slot keypad reference model.
module tb_hex_keypad_entry;

    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] hex_num_4digit;
    logic        we;
    logic [15:0] keys = 16'h0000;

    int n_cmp = 0;
    int n_bad = 0;
    int we_total = 0;

    // Reference model: keypad scanner described in plain integers.
    int          m_mode;
    int          m_row;
    int          m_cnt;
    int          m_code;
    logic [15:0] m_val;
    int          digit_of [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    typedef struct {
        int          code;
        int          press;
        int          rel;
        logic [15:0] exp_hex;
    } vec_t;
    vec_t vecs [5];

    hex_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef KEYPAD_CLEAR_EN
        .clr            (clr),
`endif
        .col            (col),
        .row            (row),
        .hex_num_4digit (hex_num_4digit),
        .WE             (we)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_row  = 0;
        m_cnt  = 0;
        m_code = 0;
        m_val  = 16'h0000;
    endtask

    task automatic model_sample(input bit clr_now, output bit we_exp);
        int lows;
        int lc;
        bit acc;
        lows = 0;
        lc   = 0;
        acc  = 1'b0;
        for (int c = 0; c < 4; c++)
            if (keys[m_row*4+c]) begin
                lows++;
                lc = c;
            end
        case (m_mode)
            0: begin
                if (lows == 1) begin
                    m_code = m_row*4 + lc;
                    m_cnt  = 1;
                    if (m_cnt >= DS) acc = 1'b1;
                    else m_mode = 1;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            1: begin
                if (lows == 1 && lc == m_code % 4) begin
                    m_cnt++;
                    if (m_cnt >= DS) acc = 1'b1;
                end else begin
                    m_mode = 0;
                    m_cnt  = 0;
                    m_row  = (m_row + 1) % 4;
                end
            end
            default: begin
                if (lows == 0) begin
                    m_cnt++;
                    if (m_cnt >= DS) begin
                        m_mode = 0;
                        m_cnt  = 0;
                        m_row  = (m_row + 1) % 4;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
        endcase
        if (acc) begin
            m_val  = {m_val[11:0], 4'(digit_of[m_code])};
            m_mode = 2;
            m_cnt  = 0;
        end
        if (clr_now) m_val = 16'h0000;
        we_exp = acc || clr_now;
    endtask

    // One scan slot; clr_last raises clr for the cycle ending on the sample edge.
    task automatic step(input bit clr_last);
        int         seen;
        bit         we_exp;
        logic [3:0] exp_row;
        seen = 0;
        for (int i = 0; i < SD; i++) begin
            if (i == SD-1 && clr_last) clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            if (we) seen++;
        end
        model_sample(clr_last, we_exp);
        exp_row = 4'hF & ~(4'b0001 << m_row);
        check("row", {28'd0, row}, {28'd0, exp_row});
        check("hex", {16'd0, hex_num_4digit}, {16'd0, m_val});
        check("we_pulses", seen, {31'd0, we_exp});
        we_total += seen;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_row", {28'd0, row}, 32'h0000_000E);
        check("rst_hex", {16'd0, hex_num_4digit}, 32'h0);
        check("rst_we", {31'd0, we}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_row(input int r);
        for (int i = 0; i < 8 && m_row != r; i++) step(1'b0);
    endtask

    task automatic press_key(input int code, input int press, input int rel);
        keys = 16'h0001 << code;
        steps(press);
        keys = 16'h0000;
        steps(rel);
    endtask

    initial begin
        int base;
        int kind;
        int hold;
        bit clr_r;

        vecs[0] = '{0, 10, 4, 16'h0061};
        vecs[1] = '{1, 10, 4, 16'h0612};
        vecs[2] = '{2, 10, 4, 16'h6123};
        vecs[3] = '{3, 10, 4, 16'h123A};
        vecs[4] = '{7, 10, 4, 16'h23AB};

        rst = 1'b1;
        model_reset();
        do_reset();

        // '6' held 10 slots then released: one entry, row held until 3 clean samples
        keys = 16'h0001 << 6;
        steps(10);
        check("k6_hex", {16'd0, hex_num_4digit}, 32'h0006);
        check("k6_we_total", we_total, 1);
        check("k6_row_held", {28'd0, row}, 32'hD);
        keys = 16'h0000;
        step(1'b0);
        check("rel1_row", {28'd0, row}, 32'hD);
        step(1'b0);
        check("rel2_row", {28'd0, row}, 32'hD);
        step(1'b0);
        check("rel3_row", {28'd0, row}, 32'hB);

        // 1,2,3,A,B each released; oldest nibble shifts out
        base = we_total;
        for (int v = 0; v < 5; v++) begin
            int b;
            b = we_total;
            press_key(vecs[v].code, vecs[v].press, vecs[v].rel);
            check("seq_hex", {16'd0, hex_num_4digit}, {16'd0, vecs[v].exp_hex});
            check("seq_we", we_total - b, 1);
        end
        check("seq_we_total", we_total - base, 5);

        // Bounce on r0c0, then a clean 3-sample press
        base = we_total;
        wait_row(0);
        keys = 16'h0001; step(1'b0);
        keys = 16'h0000; step(1'b0);
        keys = 16'h0001; step(1'b0);
        keys = 16'h0000;
        check("bounce_we", we_total - base, 0);
        check("bounce_hex", {16'd0, hex_num_4digit}, 32'h23AB);
        wait_row(0);
        keys = 16'h0001;
        steps(2);
        check("db2_hex", {16'd0, hex_num_4digit}, 32'h23AB);
        step(1'b0);
        check("db3_nibble", {28'd0, hex_num_4digit[3:0]}, 32'h1);
        check("db3_hex", {16'd0, hex_num_4digit}, 32'h3AB1);
        keys = 16'h0000;
        steps(4);

        // Two columns low in row 2: ignored, scanning continues
        base = we_total;
        keys = (16'h0001 << 8) | (16'h0001 << 9);
        steps(8);
        check("twocol_we", we_total - base, 0);
        check("twocol_hex", {16'd0, hex_num_4digit}, 32'h3AB1);
        keys = 16'h0000;

        // Reset mid-debounce of '9'; key kept down through reset release
        wait_row(2);
        keys = 16'h0001 << 10;
        steps(2);
        do_reset();
        steps(4);
        check("rst_no_accept", {16'd0, hex_num_4digit}, 32'h0);
        step(1'b0);
        check("rst_fresh_accept", {16'd0, hex_num_4digit}, 32'h0009);
        keys = 16'h0000;
        steps(4);

`ifdef KEYPAD_CLEAR_EN
        press_key(0, 10, 4);
        press_key(1, 10, 4);
        press_key(2, 10, 4);
        press_key(4, 10, 4);
        check("load_1234", {16'd0, hex_num_4digit}, 32'h1234);
        wait_row(1);
        base = we_total;
        keys = 16'h0001 << 5;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("clr_wins_hex", {16'd0, hex_num_4digit}, 32'h0);
        check("clr_wins_we", we_total - base, 1);
        steps(2);
        check("clr_held_hex", {16'd0, hex_num_4digit}, 32'h0);
        keys = 16'h0000;
        steps(4);
`endif

        // Randomized key activity against the model
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)
                keys = 16'h0001 << $urandom_range(0, 15);
            else if (kind < 8)
                keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            else
                keys = 16'h0000;
            hold = $urandom_range(1, 8);
            for (int s = 0; s < hold; s++) begin
                clr_r = 1'b0;
`ifdef KEYPAD_CLEAR_EN
                clr_r = ($urandom_range(0, 9) == 0);
`endif
                step(clr_r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
